// File: rtl/rng_pkg.sv
// Shared constants and the feedback helper for the LFSR random sources.
// Default masks are primitive for the Fibonacci shift used by lfsr_core.
package rng_pkg;

    localparam logic [7:0]  TapsW8   = 8'h8E;
    localparam logic [7:0]  SeedW8   = 8'h01;
    localparam logic [12:0] TapsW13  = 13'h100D;
    localparam logic [12:0] SeedW13  = 13'h000F;
    localparam logic [15:0] TapsW16  = 16'h8016;
    localparam logic [15:0] SeedW16  = 16'hACE1;
    localparam logic [31:0] TapsW32  = 32'hE000_0200;
    localparam logic [31:0] SeedW32  = 32'h0000_0001;

    // Chunk counter width; covers CHUNK up to 255.
    localparam int unsigned CntW = 8;

    function automatic logic lfsr_fb(input logic [31:0] state, input logic [31:0] taps);
        return ^(state & taps);
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register with reseed and all-zero lock-up recovery.
// Priority: load, then zero guard, then step.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = TapsW13,
    parameter logic [WIDTH-1:0] SEED  = SeedW13
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_next
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             fb;

    always_comb begin
        fb         = lfsr_fb(32'(state_q), 32'(TAPS));
        state_next = {state_q[WIDTH-2:0], fb};
        state_d    = state_q;
        if (load) begin
            state_d = (seed_in == '0) ? SEED : seed_in;
        end else if (state_q == '0) begin
            state_d = SEED;
        end else if (step) begin
            state_d = state_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/lfsr_rng.sv
// LFSR random source with a chunk counter, single-entry valid/ready output
// buffer and a sticky overrun flag for samples dropped while the buffer is full.
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 13,
    parameter logic [WIDTH-1:0] TAPS  = TapsW13,
    parameter logic [WIDTH-1:0] SEED  = SeedW13,
    parameter int unsigned      CHUNK = 13
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clr_overrun
);

    localparam logic [CntW-1:0] CntLast = CntW'(CHUNK - 1);

    logic [WIDTH-1:0] state, state_next;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             zero_state, shift_en, complete, drain, drop;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clock      (clock),
        .resetn     (resetn),
        .load       (load),
        .seed_in    (seed_in),
        .step       (enable),
        .state      (state),
        .state_next (state_next)
    );

    always_comb begin
        zero_state = (state == '0);
        // Only a real shift counts; load and the zero guard both restart the chunk.
        shift_en   = enable & ~load & ~zero_state;
        complete   = shift_en & (cnt_q == CntLast);
        drain      = valid_q & out_ready;
        drop       = 1'b0;

        cnt_d = cnt_q;
        if (load || zero_state) begin
            cnt_d = '0;
        end else if (shift_en) begin
            cnt_d = complete ? '0 : cnt_q + CntW'(1);
        end

        data_d  = data_q;
        valid_d = valid_q & ~drain;
        if (complete) begin
            if (!valid_q || drain) begin
                data_d  = state_next;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end

        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;

endmodule

// File: doc/lfsr_rng.md
# lfsr_rng

Parametrised Fibonacci-LFSR pseudo-random source with a buffered, handshaked sample output. It is the next generation of the project's 13-bit random generator. Width, taps, seed and shifts-per-sample are parameters, and it adds runtime reseeding, an all-zero lock-up guard, a valid/ready output and overrun detection. Game and sprite logic consume one sample per accepted handshake.

## Interface
- `WIDTH`, 13: LFSR state width, range 3–32.
- `TAPS`, `13'h100D`: feedback mask. The bit i set means `state[i]` is XORed into the feedback. Bit `WIDTH-1` must be set.
- `SEED`, `13'h000F`: reset seed. It also replaces any all-zero seed. Must be nonzero.
- `CHUNK`, 13: enabled shifts per emitted sample, range 1–255.
- `clock`, in, 1: single clock; all logic is on the rising edge.
- `resetn`, in, 1: synchronous, active-low reset.
- `enable`, in, 1: shift the LFSR this cycle.
- `load`, in, 1: reseed from `seed_in` this cycle.
- `seed_in`, in, `WIDTH`: seed value used when `load` is high.
- `out_data`, out, `WIDTH`: the sample, a snapshot of the LFSR state.
- `out_valid`, out, 1: `out_data` holds an unconsumed sample.
- `out_ready`, in, 1: the consumer accepts the sample.
- `overrun`, out, 1: sticky flag; a completed sample was dropped.
- `clr_overrun`, in, 1: clears `overrun`.

## Operation
- Shift rule: `fb = ^(state & TAPS)`; `state_next = {state[WIDTH-2:0], fb}`.
- Counter `cnt` runs 0..CHUNK-1 and advances only on enabled shifts.
- When an enabled shift occurs with `cnt == CHUNK-1`, that is a sample completion:
  - `cnt` wraps to 0.
  - The post-shift state `state_next` is the completed sample.
- The output buffer is a single entry.
  - If the buffer is empty, or is being drained this cycle (`out_valid & out_ready`), the sample is written to `out_data` and `out_valid` is set.
  - Otherwise the sample is dropped, `out_data` keeps the old sample, and `overrun` is set.
- Handshake:
  - A transfer occurs on any edge where `out_valid & out_ready`.
  - `out_valid` clears unless a new sample is written on the same edge.
  - `out_data` is stable while `out_valid` is high and no transfer occurs.
- Load has priority over enable.
  - `state <= (seed_in == 0) ? SEED : seed_in`, and `cnt <= 0`.
  - No sample completes on a load cycle.
  - The buffer and `overrun` are unaffected.
- Lock-up guard: if `state == 0` is ever seen, for example after an upset, the next edge reloads `SEED` in place of shifting and sets `cnt <= 0`.
- `clr_overrun` clears `overrun`. If a drop happens on the same edge, the set wins.
- The `enable = 0` and `load = 0` case leaves state and `cnt` unchanged, but handshake transfers still occur.

## Timing
- Reset applies on an edge where `resetn = 0`. Values after that edge:
  - `state = SEED`, `cnt = 0`.
  - `out_valid = 0`, `out_data = 0`, `overrun = 0`.
- Reset mid-operation discards the pending sample and the partial count.
- Latency: with `enable` held high from reset release, `out_valid` rises after the `CHUNK`-th rising edge. Samples are spaced exactly `CHUNK` enabled cycles apart.
- `out_valid` and `out_data` are registered, with no combinational path from `out_ready`.
- A consumer holding `out_ready = 1` never causes an overrun for any `CHUNK` ≥ 1.
- `CHUNK = 1` emits one sample per enabled cycle.
- The sequence period is 2^WIDTH−1 if `TAPS` is primitive. The default 13-bit mask is primitive.

## Structure
- Package `rng_pkg`:
  - default `TAPS`/`SEED` constants for widths 8, 13, 16 and 32;
  - the `lfsr_fb` feedback function.
- Sub-module `lfsr_core` (`WIDTH`, `TAPS`, `SEED`): holds the state register, shift, load and zero guard. Its inputs are `load`, `seed_in` and `step`; its outputs are `state` and `state_next`.
- The top level holds the chunk counter, the output buffer, the handshake and the overrun logic.

## Test plan
- Reset, `CHUNK = 4`, defaults, `enable = 1`, `out_ready = 1` → `out_valid` rises after edge 4 with `out_data = 13'h00FF`, and the next sample is `13'h0FFF`.
- `CHUNK = 4`, `out_ready = 0` for 12 enabled cycles → the first sample `13'h00FF` is held, `overrun = 1` after edge 8, and `out_data` is unchanged. A `clr_overrun` pulse clears the flag.
- `load = 1` with `seed_in = 0` → state becomes `13'h000F` and the sequence repeats from reset. A `load` during `cnt = 2` restarts the count, so the next sample comes 4 enabled cycles later.
- Buffer full and `out_ready = 1` on the sample-completion edge → the old sample transfers, the new one is captured, `out_valid` stays 1, and `overrun` stays 0.
- `enable` toggled every other cycle → a sample appears every 4 enabled cycles. Handshakes on idle cycles complete, and the state is frozen on idle cycles.
- `WIDTH = 4`, `TAPS = 4'h9`, `CHUNK = 1`, free-running → the period is 15 with no zero state. `resetn` low mid-stream clears `out_valid` on the next edge.
